ins_block_memory: RTL

- Main instruction memory directly downstream of the instruction cache. Serves 128-bit, four-word blocks on a cache miss.
- Uses a read/busywait handshake with a fixed, parameterised latency, which models slow main memory.
- Includes a word-wide load port so benches and boot logic can preload program images.
- Sits between the instruction cache's main-memory port and the program loader.

---
 rtl/ins_block_memory.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ins_block_memory.sv
// Main instruction memory behind the instruction cache.
// Serves 128-bit, four-word blocks over a read/busywait handshake with a fixed
// latency, and accepts single-word program loads while idle.
module ins_block_memory #(
  parameter int unsigned INDEX_BITS   = 8,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [27:0]  address,
  output logic [127:0] readdata,
  output logic         busywait,
  input  logic         load_en,
  input  logic [31:0]  load_addr,
  input  logic [31:0]  load_data,
  output logic         load_ack
);

  localparam int unsigned DEPTH   = 2 ** INDEX_BITS;
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [BLK_W-1:0] NOP_BLOCK = 128'h00000013_00000013_00000013_00000013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLK_W-1:0]    readdata_q, readdata_d;
  logic                load_ack_q, load_ack_d;

  // Block storage; intentionally not reset so a loaded program survives reset.
  logic [BLK_W-1:0]    mem_q [DEPTH];

  logic                busywait_c;
  logic                load_we_c;
  logic [INDEX_BITS-1:0] load_idx_c;
  logic [1:0]          load_lane_c;
  logic                load_in_range_c;
  logic                addr_in_range_c;
  logic [BLK_W-1:0]    rd_block_c;
  logic                unused_load_bits_c;

  // Address decode for the load port and the latched read address.
  assign load_idx_c         = load_addr[INDEX_BITS+3:4];
  assign load_lane_c        = load_addr[3:2];
  assign load_in_range_c    = ((load_addr >> (INDEX_BITS + 4)) == '0);
  assign addr_in_range_c    = ((addr_q >> INDEX_BITS) == '0);
  assign rd_block_c         = mem_q[addr_q[INDEX_BITS-1:0]];
  assign unused_load_bits_c = ^load_addr[1:0];

  // State register and datapath flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      readdata_q <= '0;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      readdata_q <= readdata_d;
      load_ack_q <= load_ack_d;
    end
  end

  // Next-state logic: a read always runs to completion through one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (read) state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; read wins over a coincident load.
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    readdata_d = readdata_q;
    load_ack_d = 1'b0;
    load_we_c  = 1'b0;
    busywait_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        busywait_c = read;
        if (read) begin
          addr_d = address;
          cnt_d  = CNT_W'(READ_LATENCY - 1);
        end else if (load_en && load_in_range_c) begin
          load_we_c  = 1'b1;
          load_ack_d = 1'b1;
        end
      end
      S_BUSY: begin
        busywait_c = 1'b1;
        if (cnt_q == '0) begin
          readdata_d = addr_in_range_c ? rd_block_c : NOP_BLOCK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        busywait_c = 1'b0;
      end
      default: begin
        busywait_c = 1'b0;
      end
    endcase
  end

  // Single-lane program-load write; other lanes of the block are preserved.
  always_ff @(posedge clock) begin
    if (load_we_c) begin
      mem_q[load_idx_c][{load_lane_c, 5'd0} +: 32] <= load_data;
    end
  end

  // Busywait is combinational so the cache sees busy in the cycle it raises read;
  // gated by reset so it drops immediately when reset is asserted.
  assign busywait = busywait_c & reset;
  assign readdata = readdata_q;
  assign load_ack = load_ack_q;

endmodule
